seven_seg_scanner: RTL and testbench

Parametrised time-multiplexed display scanner for the chess-clock front panel. It drives N common-select digits from a flat segment bus and adds four features: inter-digit blanking against ghosting, per-slot brightness control, per-digit blink, and per-digit enable. It sits between the time-to-segment encoders and the board pins, and is clocked from the system clock with a prescaled CE strobe.

---
 rtl/seven_seg_scanner.sv | 145 ++++++++++++++
 tb/tb_seven_seg_scanner.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner
//   Time-multiplexed scanner for N_DIGITS common-select digits. Each digit
//   owns a slot of DWELL CE ticks. The first BLANK ticks of every slot are dark
//   to suppress ghosting. After that the digit is lit for up to `brightness`
//   ticks, gated by enable_mask and by the blink phase for digits selected in
//   blink_mask. The segment pattern is latched at slot start, so a change to
//   seg_in only shows up in that digit's next slot.
//
// Ports
//   CLK          system clock, rising edge
//   CLR          synchronous active-high reset
//   CE           scan tick enable
//   seg_in       N_DIGITS*SEG_W segment patterns, digit d at [d*SEG_W +: SEG_W]
//   enable_mask  per-digit show enable
//   blink_mask   per-digit blink enable
//   brightness   lit ticks per slot after blanking (saturating)
//   seg_out      registered segment drive (pin polarity)
//   seg_select   registered one-hot-or-zero digit select (pin polarity)
//   digit_idx    registered index of the current slot (scan state for debug)
//   frame_tick   one-cycle pulse after each completed frame
module seven_seg_scanner #(
    parameter int N_DIGITS       = 8,
    parameter int SEG_W          = 8,
    parameter int DWELL          = 16,
    parameter int BLANK          = 2,
    parameter int BLINK_FRAMES   = 64,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int SEL_ACTIVE_LOW = 0,
    localparam int BW            = $clog2(DWELL + 1),
    localparam int IW            = $clog2(N_DIGITS)
) (
    input  logic                      CLK,
    input  logic                      CLR,
    input  logic                      CE,
    input  logic [N_DIGITS*SEG_W-1:0] seg_in,
    input  logic [N_DIGITS-1:0]       enable_mask,
    input  logic [N_DIGITS-1:0]       blink_mask,
    input  logic [BW-1:0]             brightness,
    output logic [SEG_W-1:0]          seg_out,
    output logic [N_DIGITS-1:0]       seg_select,
    output logic [IW-1:0]             digit_idx,
    output logic                      frame_tick
);

    localparam int TW = $clog2(DWELL);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [SEG_W-1:0]    SEG_INV = (SEG_ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [N_DIGITS-1:0] SEL_INV = (SEL_ACTIVE_LOW != 0) ? '1 : '0;

    logic [TW-1:0]    tick_q, tick_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [FW-1:0]    frame_q, frame_d;
    logic             blink_q, blink_d;
    logic [SEG_W-1:0] cur_seg_q, cur_seg_d;

    logic [SEG_W-1:0] digits [N_DIGITS];
    logic             slot_end, last_digit;

    always_comb begin
        for (int d = 0; d < N_DIGITS; d++) begin
            digits[d] = seg_in[d*SEG_W +: SEG_W];
        end
    end

    assign slot_end   = (tick_q == TW'(DWELL - 1));
    assign last_digit = (idx_q == IW'(N_DIGITS - 1));

    // State register
    always_ff @(posedge CLK) begin
        if (CLR) begin
            tick_q    <= '0;
            idx_q     <= '0;
            frame_q   <= '0;
            blink_q   <= 1'b0;
            cur_seg_q <= digits[0];
        end else begin
            tick_q    <= tick_d;
            idx_q     <= idx_d;
            frame_q   <= frame_d;
            blink_q   <= blink_d;
            cur_seg_q <= cur_seg_d;
        end
    end

    // Next state: advance only on CE; explicit compare-and-clear on idx keeps
    // non-power-of-two digit counts from reaching an illegal index.
    always_comb begin
        tick_d    = tick_q;
        idx_d     = idx_q;
        frame_d   = frame_q;
        blink_d   = blink_q;
        cur_seg_d = cur_seg_q;
        if (CE) begin
            if (slot_end) begin
                tick_d    = '0;
                idx_d     = last_digit ? '0 : idx_q + 1'b1;
                cur_seg_d = digits[idx_d];
                if (last_digit) begin
                    if (frame_q == FW'(BLINK_FRAMES - 1)) begin
                        frame_d = '0;
                        blink_d = ~blink_q;
                    end else begin
                        frame_d = frame_q + 1'b1;
                    end
                end
            end else begin
                tick_d = tick_q + 1'b1;
            end
        end
    end

    // Output decode from current state and live masks/brightness
    logic [31:0]         eff, rel;
    logic                lit;
    logic [N_DIGITS-1:0] sel_d;
    logic [SEG_W-1:0]    seg_d;

    always_comb begin
        eff = (32'(brightness) > 32'(DWELL - BLANK)) ? 32'(DWELL - BLANK)
                                                      : 32'(brightness);
        // Ticks inside the blank window wrap to a huge value and never pass.
        rel = 32'(tick_q) - 32'(BLANK);
        lit = (rel < eff) && enable_mask[idx_q] && !(blink_q && blink_mask[idx_q]);
        for (int d = 0; d < N_DIGITS; d++) begin
            sel_d[d] = lit && (idx_q == IW'(d));
        end
        seg_d = lit ? cur_seg_q : '0;
    end

    // Output register, polarity applied at the pins
    always_ff @(posedge CLK) begin
        if (CLR) begin
            seg_out    <= SEG_INV;
            seg_select <= SEL_INV;
            digit_idx  <= '0;
            frame_tick <= 1'b0;
        end else begin
            seg_out    <= seg_d ^ SEG_INV;
            seg_select <= sel_d ^ SEL_INV;
            digit_idx  <= idx_q;
            frame_tick <= CE && slot_end && last_digit;
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
module tb_seven_seg_scanner;

    logic CLK = 1'b0;
    logic CLR = 1'b1;
    logic CE  = 1'b0;

    // Instance A: 4 digits, DWELL 4, BLANK 1, blink every 2 frames, active-high
    logic [31:0] seg_in_a = '0;
    logic [3:0]  en_a = '0, bm_a = '0;
    logic [2:0]  br_a = '0;
    logic [7:0]  seg_out_a;
    logic [3:0]  sel_a;
    logic [1:0]  idx_a;
    logic        ft_a;

    // Instance B: 5 digits, DWELL 3, BLANK 0, blink every frame, active-low pins
    logic [39:0] seg_in_b = '0;
    logic [4:0]  en_b = '0, bm_b = '0;
    logic [1:0]  br_b = '0;
    logic [7:0]  seg_out_b;
    logic [4:0]  sel_b;
    logic [2:0]  idx_b;
    logic        ft_b;

    seven_seg_scanner #(
        .N_DIGITS(4), .SEG_W(8), .DWELL(4), .BLANK(1), .BLINK_FRAMES(2),
        .SEG_ACTIVE_LOW(0), .SEL_ACTIVE_LOW(0)
    ) dut_a (
        .CLK(CLK), .CLR(CLR), .CE(CE), .seg_in(seg_in_a),
        .enable_mask(en_a), .blink_mask(bm_a), .brightness(br_a),
        .seg_out(seg_out_a), .seg_select(sel_a), .digit_idx(idx_a),
        .frame_tick(ft_a)
    );

    seven_seg_scanner #(
        .N_DIGITS(5), .SEG_W(8), .DWELL(3), .BLANK(0), .BLINK_FRAMES(1),
        .SEG_ACTIVE_LOW(1), .SEL_ACTIVE_LOW(1)
    ) dut_b (
        .CLK(CLK), .CLR(CLR), .CE(CE), .seg_in(seg_in_b),
        .enable_mask(en_b), .blink_mask(bm_b), .brightness(br_b),
        .seg_out(seg_out_b), .seg_select(sel_b), .digit_idx(idx_b),
        .frame_tick(ft_b)
    );

    // Clock
    always #5 CLK = ~CLK;

    // Scoreboard counters
    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Reference model: the scan is fully described by k, the number of CE
    // ticks since reset, plus the segment pattern latched at each slot start.
    int         ka = 0, kb = 0;
    logic [7:0] lat_a = '0, lat_b = '0;
    logic [7:0] e_seg_a, e_seg_b;
    logic [3:0] e_sel_a;
    logic [4:0] e_sel_b;
    logic [1:0] e_idx_a;
    logic [2:0] e_idx_b;
    logic       e_ft_a, e_ft_b;

    function automatic bit model_lit(int k, int n, int dw, int bl, int bf, int br,
                                     logic [7:0] en, logic [7:0] bm);
        int t, d, fr, ph, eff;
        t   = k % dw;
        d   = (k / dw) % n;
        fr  = k / (n * dw);
        ph  = (fr / bf) % 2;
        eff = (br > dw - bl) ? dw - bl : br;
        return (t >= bl) && (t < bl + eff) && en[d] && !(ph == 1 && bm[d]);
    endfunction

    // One clock: derive expectations from the model and the inputs now
    // applied, advance the model, then compare just after the edge.
    task automatic cycle();
        int  d;
        bit  lit;
        if (CLR) begin
            ka = 0; kb = 0;
            lat_a = seg_in_a[7:0];
            lat_b = seg_in_b[7:0];
            e_seg_a = 8'h00; e_sel_a = 4'h0;  e_idx_a = 2'd0; e_ft_a = 1'b0;
            e_seg_b = 8'hFF; e_sel_b = 5'h1F; e_idx_b = 3'd0; e_ft_b = 1'b0;
        end else begin
            d   = (ka / 4) % 4;
            lit = model_lit(ka, 4, 4, 1, 2, int'(br_a), 8'(en_a), 8'(bm_a));
            e_sel_a = lit ? 4'(1 << d) : 4'h0;
            e_seg_a = lit ? lat_a : 8'h00;
            e_idx_a = 2'(d);
            e_ft_a  = CE && ((ka + 1) % 16 == 0);
            if (CE) begin
                ka++;
                if (ka % 4 == 0) lat_a = seg_in_a[((ka / 4) % 4) * 8 +: 8];
            end

            d   = (kb / 3) % 5;
            lit = model_lit(kb, 5, 3, 0, 1, int'(br_b), 8'(en_b), 8'(bm_b));
            e_sel_b = (lit ? 5'(1 << d) : 5'h00) ^ 5'h1F;
            e_seg_b = (lit ? lat_b : 8'h00) ^ 8'hFF;
            e_idx_b = 3'(d);
            e_ft_b  = CE && ((kb + 1) % 15 == 0);
            if (CE) begin
                kb++;
                if (kb % 3 == 0) lat_b = seg_in_b[((kb / 3) % 5) * 8 +: 8];
            end
        end
        @(posedge CLK);
        #1;
        chk("a_seg_out", 64'(seg_out_a), 64'(e_seg_a));
        chk("a_select",  64'(sel_a),     64'(e_sel_a));
        chk("a_idx",     64'(idx_a),     64'(e_idx_a));
        chk("a_frame",   64'(ft_a),      64'(e_ft_a));
        chk("b_seg_out", 64'(seg_out_b), 64'(e_seg_b));
        chk("b_select",  64'(sel_b),     64'(e_sel_b));
        chk("b_idx",     64'(idx_b),     64'(e_idx_b));
        chk("b_frame",   64'(ft_b),      64'(e_ft_b));
        @(negedge CLK);
    endtask

    task automatic rand_b();
        seg_in_b = {$urandom, $urandom};
        en_b     = 5'($urandom);
        bm_b     = 5'($urandom);
        br_b     = 2'($urandom_range(0, 3));
    endtask

    initial begin
        int first_lit;
        int last_ft, ft_gap;
        @(negedge CLK);

        // Reset held for three cycles
        CLR = 1'b1; CE = 1'b1;
        seg_in_a = 32'h8844_2211; en_a = 4'hF; bm_a = 4'h0; br_a = 3'd3;
        rand_b();
        en_b = 5'h1F; bm_b = 5'h00; br_b = 2'd3;
        repeat (3) cycle();
        CLR = 1'b0;

        // Plain scan: first lit slot arrives two cycles after release
        first_lit = -1;
        last_ft = -1; ft_gap = 0;
        for (int i = 1; i <= 40; i++) begin
            cycle();
            if (first_lit < 0 && sel_a != 4'h0) first_lit = i;
            if (ft_a) begin
                if (last_ft >= 0) ft_gap = i - last_ft;
                last_ft = i;
            end
        end
        chk("first_lit_cycle", 64'(first_lit), 64'd2);
        chk("frame_tick_gap", 64'(ft_gap), 64'd16);

        // Brightness sweep including saturation
        br_a = 3'd1; repeat (32) cycle();
        br_a = 3'd0; repeat (32) cycle();
        br_a = 3'd7; repeat (32) cycle();

        // Blink on digit 2, then digit 0 disabled
        br_a = 3'd3; bm_a = 4'b0100;
        repeat (96) cycle();
        en_a = 4'b1110;
        repeat (64) cycle();
        en_a = 4'hF; bm_a = 4'h0;

        // CE 1-in-3 with a mid-slot update of digit 1
        seg_in_a[15:8] = 8'h22;
        for (int i = 0; i < 240; i++) begin
            CE = (i % 3 == 0);
            if (ka % 16 == 5) seg_in_a[15:8] = 8'h7F;
            cycle();
        end
        seg_in_a[15:8] = 8'h22;
        CE = 1'b1;

        // Reset mid-slot at digit 2, tick 2
        for (int i = 0; i < 40 && (ka % 16) != 10; i++) cycle();
        chk("midslot_reach", 64'(ka % 16), 64'd10);
        CLR = 1'b1; cycle();
        CLR = 1'b0;
        repeat (40) cycle();

        // Fully random traffic, including occasional resets
        for (int i = 0; i < 2200; i++) begin
            CE  = ($urandom_range(0, 3) != 0);
            CLR = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 3) == 0) seg_in_a = $urandom;
            if ($urandom_range(0, 15) == 0) en_a = 4'($urandom);
            if ($urandom_range(0, 15) == 0) bm_a = 4'($urandom);
            if ($urandom_range(0, 15) == 0) br_a = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) rand_b();
            cycle();
        end
        CLR = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
